prog_ram_loader: RTL
====================

# prog_ram_loader

Writable 32 x 9 instruction store that replaces the fixed ROM in front of the `proc` datapath. In LOAD mode an operator enters 9-bit instruction words one at a time from the switches, with one write per pushbutton strobe. In RUN mode the stored program is played back to the processor's `DIN`, one word per fetch advance, and wraps at the end of the loaded program. It is the write side of the counter-plus-ROM fetch path and sits between the board switches/keys and `proc`.

## Interface
Parameters:
- `n`, 5, address width.
- `k`, 32, memory depth in words (k <= 2^n).
- `w`, 9, word width; matches `DIN`.

Ports:
- `Clock`  in  1  single system clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Load`  in  1  level: 1 = load mode, 0 = run mode.
- `Strobe`  in  1  asynchronous write request from a pushbutton, active high.
- `Data`  in  w  word to be written.
- `Next`  in  1  fetch advance, synchronous to `Clock`, one cycle per fetch.
- `DOUT`  out  w  registered read data; drives `proc` `DIN`.
- `Addr`  out  n  current pointer: write pointer in LOAD, read pointer in RUN.
- `WrCount`  out  n+1  number of valid words, 0..k.
- `Full`  out  1  `WrCount == k`.
- `Busy`  out  1  1 while in LOAD state.

## Operation
- States: IDLE, LOAD, RUN.
- Reset (dominant over every other input, in any state):
  - state = IDLE; write pointer `wptr` = 0; read pointer `rptr` = 0; `WrCount` = 0; `DOUT` = 0.
  - Synchronizer flops = 0; `Addr` = 0; `Full` = 0; `Busy` = 0.
  - Memory contents are not cleared.
- IDLE:
  - `Load` = 1 -> LOAD, with `wptr` = 0 and `WrCount` = 0.
  - `Load` = 0 -> RUN.
- LOAD:
  - `Strobe` passes through a two-flop synchronizer (s1, s2) plus an edge flop s3. The write pulse is `s2 & ~s3`.
  - On a write pulse with `Full` = 0: `mem[wptr]` <= `Data`, `wptr` + 1, `WrCount` + 1.
  - On a write pulse with `Full` = 1: ignored; no state changes.
  - A held `Strobe` produces exactly one write.
  - `Load` = 0 -> RUN with `rptr` = 0. A write pulse in the same cycle still commits before the transition.
- RUN:
  - `Next` = 1 and `WrCount` > 0: `DOUT` <= `mem[rptr]`; then `rptr` = (`rptr` == `WrCount` - 1) ? 0 : `rptr` + 1.
  - `Next` = 1 and `WrCount` = 0: `DOUT` held at its current value; `rptr` stays 0.
  - `Next` = 0: `DOUT` and `rptr` hold.
  - `Load` = 1 -> LOAD. `wptr` and `WrCount` clear to 0 (reload from scratch); `DOUT` holds its last value.
  - A `Next` in the same cycle as `Load` rising is ignored.
- The synchronizer runs in all states. Strobe edges seen outside LOAD are discarded.
- `Addr` = `wptr` in LOAD, `rptr` otherwise.
- `Busy` = (state == LOAD).
- `Full` is combinational from `WrCount`.

## Timing
- Write latency: `Strobe` rising before clock edge E0 commits the write at E2 (the third rising edge). `WrCount` and `Addr` update at E2.
- Read latency: `Next` sampled high at edge E updates `DOUT` at E, giving one-cycle registered-read behaviour equivalent to the ROM it replaces.
- Pointer wrap happens on the same edge as the read of the last valid word.
- Mode changes take effect on the edge where `Load` is sampled. The first RUN read can occur on the following edge.
- Reset asserted mid-write or mid-read:
  - Outputs reach reset values at the next edge.
  - Any partially synchronized strobe is lost.
  - No write commits on the reset edge.

## Test plan
- Reset values: hold `Reset` 2 cycles, then release with `Load` = 0 -> `DOUT` = 0, `WrCount` = 0, `Addr` = 0, `Full` = 0, `Busy` = 0, state RUN. Pulse `Next` -> `DOUT` stays 0.
- Load 3 and play back: `Load` = 1; strobe `Data` = 9'h1C0, 9'h048, 9'h0A5 -> `WrCount` = 3, `Addr` = 3. Set `Load` = 0, then 5 `Next` pulses -> `DOUT` sequence 1C0, 048, 0A5, 1C0, 048.
- Held strobe: hold `Strobe` high for 20 cycles with `Data` = 9'h111 -> exactly one write, `WrCount` += 1. Also check the write lands on the third edge after `Strobe` rises.
- Full boundary: write 32 words with values 0..31 -> `Full` = 1, `Addr` = 0 (wrapped n-bit). A 33rd strobe leaves `mem[0]` = 0 and `WrCount` = 32. Playback of 33 `Next` pulses returns 0..31, then 0.
- Reload mid-run: after 2 reads of a 3-word program, raise `Load` together with `Next` -> `Next` ignored, `WrCount` = 0, `DOUT` unchanged. Write 9'h0FF, drop `Load`, pulse `Next` -> `DOUT` = 9'h0FF repeatedly.
- Reset mid-operation: assert `Reset` on the edge where a strobe edge would commit -> no write, `WrCount` = 0, `DOUT` = 0.

Source files
------------

// File: rtl/prog_ram_loader_if.sv
// rtl/prog_ram_loader_if.sv - operator/fetch-side signal bundle for the program RAM loader
interface prog_ram_loader_if #(
  parameter int n = 5,
  parameter int w = 9
);
  logic         Load;
  logic         Strobe;
  logic [w-1:0] Data;
  logic         Next;
  logic [w-1:0] DOUT;
  logic [n-1:0] Addr;
  logic [n:0]   WrCount;
  logic         Full;
  logic         Busy;

  modport master (
    output Load, Strobe, Data, Next,
    input  DOUT, Addr, WrCount, Full, Busy
  );

  modport slave (
    input  Load, Strobe, Data, Next,
    output DOUT, Addr, WrCount, Full, Busy
  );
endinterface

// File: rtl/prog_ram_loader.sv
// rtl/prog_ram_loader.sv - writable instruction store loaded from switches, played back to proc DIN
module prog_ram_loader #(
  parameter int n = 5,
  parameter int k = 32,
  parameter int w = 9
) (
  input logic              Clock,
  input logic              Reset,
  prog_ram_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e       state_q;
  logic [n-1:0] wptr_q;
  logic [n-1:0] rptr_q;
  logic [n:0]   cnt_q;
  logic [w-1:0] dout_q;
  logic         s1_q, s2_q, s3_q;
  logic [w-1:0] mem_q [k];

  logic wr_pulse;
  logic full;
  logic rptr_last;

  // s3 is an edge detector on the synchronized strobe, so a held button writes once
  assign wr_pulse  = s2_q & ~s3_q;
  assign full      = (cnt_q == (n+1)'(k));
  assign rptr_last = ({1'b0, rptr_q} == (cnt_q - (n+1)'(1)));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      s1_q <= bus.Strobe;
      s2_q <= s1_q;
      s3_q <= s2_q;
      case (state_q)
        IDLE: begin
          if (bus.Load) begin
            state_q <= LOAD;
            wptr_q  <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= RUN;
          end
        end
        LOAD: begin
          // a write pulse coinciding with Load falling still lands
          if (wr_pulse && !full) begin
            mem_q[wptr_q] <= bus.Data;
            wptr_q        <= wptr_q + n'(1);
            cnt_q         <= cnt_q + (n+1)'(1);
          end
          if (!bus.Load) begin
            state_q <= RUN;
            rptr_q  <= '0;
          end
        end
        RUN: begin
          if (bus.Load) begin
            state_q <= LOAD;
            wptr_q  <= '0;
            cnt_q   <= '0;
          end else if (bus.Next && cnt_q != '0) begin
            dout_q <= mem_q[rptr_q];
            rptr_q <= rptr_last ? '0 : rptr_q + n'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.DOUT    = dout_q;
  assign bus.Addr    = (state_q == LOAD) ? wptr_q : rptr_q;
  assign bus.WrCount = cnt_q;
  assign bus.Full    = full;
  assign bus.Busy    = (state_q == LOAD);

endmodule
